// File: rtl/fe_capture_sequencer.sv
// ---------------------------------------------------------------------------
// fe_capture_sequencer
//
// Sequences the front-end capture datapath. An arm edge moves the sequencer
// to ARMED, where it waits a fixed settle time and then accepts a trigger:
// either a pattern-match pulse or, in immediate mode, the first settled
// cycle. A programmable delay follows, then capture enable is held until the
// capture block stops or the optional timeout expires.
//
// Ports:
//   fe_clk            front-end clock, rising edge
//   reset_i           asynchronous active-high reset
//   I_arm             arm request level; rising edge arms from IDLE/DONE
//   I_abort           single-cycle abort, returns to IDLE from any state
//   I_trigger_mode    0 = wait for I_pm_match, 1 = trigger after settle
//   I_trigger_delay   trigger-to-enable delay in cycles (latched on trigger)
//   I_timeout         max CAPTURE cycles, 0 = unlimited (latched on arm)
//   I_pm_match        pattern-match pulse
//   I_capturing       capture-active level from the capture block
//   O_arm             arm level to capture block (ARMED/DELAY/CAPTURE)
//   O_capture_enable  capture enable (CAPTURE only)
//   O_trigger         one-cycle pulse after a trigger is accepted
//   O_done            high in DONE
//   O_timed_out       sticky: last capture ended by timeout
//   O_state           IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4
// ---------------------------------------------------------------------------
module fe_capture_sequencer #(
    parameter int pDELAY_WIDTH   = 20,
    parameter int pTIMEOUT_WIDTH = 24,
    parameter int pARM_SETTLE    = 4
) (
    input  logic                      fe_clk,
    input  logic                      reset_i,
    input  logic                      I_arm,
    input  logic                      I_abort,
    input  logic                      I_trigger_mode,
    input  logic [pDELAY_WIDTH-1:0]   I_trigger_delay,
    input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
    input  logic                      I_pm_match,
    input  logic                      I_capturing,
    output logic                      O_arm,
    output logic                      O_capture_enable,
    output logic                      O_trigger,
    output logic                      O_done,
    output logic                      O_timed_out,
    output logic [2:0]                O_state
);

    localparam int SETTLE_W = (pARM_SETTLE > 1) ? $clog2(pARM_SETTLE) : 1;
    localparam logic [SETTLE_W-1:0]       SETTLE_LOAD = SETTLE_W'(pARM_SETTLE - 1);
    localparam logic [SETTLE_W-1:0]       SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [pDELAY_WIDTH-1:0]   DLY_ONE     = pDELAY_WIDTH'(1);
    localparam logic [pTIMEOUT_WIDTH-1:0] TO_ONE      = pTIMEOUT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic                        arm_q;
    logic                        arm_edge;
    logic [SETTLE_W-1:0]         settle_q, settle_d;
    logic [pDELAY_WIDTH-1:0]     delay_q, delay_d;
    logic [pTIMEOUT_WIDTH-1:0]   tocnt_q, tocnt_d;
    logic [pTIMEOUT_WIDTH-1:0]   timeout_q, timeout_d;
    logic                        timed_out_d;
    logic                        trigger_d;

    assign arm_edge = I_arm & ~arm_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        delay_d     = delay_q;
        tocnt_d     = tocnt_q;
        timeout_d   = timeout_q;
        timed_out_d = O_timed_out;
        trigger_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_edge) begin
                    state_d     = ST_ARMED;
                    settle_d    = SETTLE_LOAD;
                    timeout_d   = I_timeout;
                    timed_out_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_ONE;
                end else if (I_trigger_mode || I_pm_match) begin
                    trigger_d = 1'b1;
                    if (I_trigger_delay == '0) begin
                        state_d = ST_CAPTURE;
                        tocnt_d = '0;
                    end else begin
                        state_d = ST_DELAY;
                        delay_d = I_trigger_delay - DLY_ONE;
                    end
                end
            end
            ST_DELAY: begin
                if (delay_q == '0) begin
                    state_d = ST_CAPTURE;
                    tocnt_d = '0;
                end else begin
                    delay_d = delay_q - DLY_ONE;
                end
            end
            ST_CAPTURE: begin
                if (tocnt_q != '1) begin
                    tocnt_d = tocnt_q + TO_ONE;
                end
                // tocnt_q is zero only in the first CAPTURE cycle, which
                // skips the I_capturing check; the capturing exit has
                // priority over the timeout exit.
                if (tocnt_q != '0 && !I_capturing) begin
                    state_d = ST_DONE;
                end else if (timeout_q != '0 && tocnt_q == timeout_q - TO_ONE) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (I_abort) begin
            state_d     = ST_IDLE;
            trigger_d   = 1'b0;
            timed_out_d = O_timed_out;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as O_state.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_IDLE;
            arm_q            <= 1'b0;
            settle_q         <= '0;
            delay_q          <= '0;
            tocnt_q          <= '0;
            timeout_q        <= '0;
            O_arm            <= 1'b0;
            O_capture_enable <= 1'b0;
            O_trigger        <= 1'b0;
            O_done           <= 1'b0;
            O_timed_out      <= 1'b0;
        end else begin
            state_q          <= state_d;
            arm_q            <= I_arm;
            settle_q         <= settle_d;
            delay_q          <= delay_d;
            tocnt_q          <= tocnt_d;
            timeout_q        <= timeout_d;
            O_arm            <= (state_d == ST_ARMED) || (state_d == ST_DELAY) ||
                                (state_d == ST_CAPTURE);
            O_capture_enable <= (state_d == ST_CAPTURE);
            O_trigger        <= trigger_d;
            O_done           <= (state_d == ST_DONE);
            O_timed_out      <= timed_out_d;
        end
    end

    assign O_state = state_q;

endmodule

// File: tb/tb_fe_capture_sequencer.sv
module tb_fe_capture_sequencer;

    localparam int DW = 20;
    localparam int TW = 24;

    logic          fe_clk = 1'b0;
    logic          reset_i;
    logic          I_arm;
    logic          I_abort;
    logic          I_trigger_mode;
    logic [DW-1:0] I_trigger_delay;
    logic [TW-1:0] I_timeout;
    logic          I_pm_match;
    logic          I_capturing;
    logic          O_arm;
    logic          O_capture_enable;
    logic          O_trigger;
    logic          O_done;
    logic          O_timed_out;
    logic [2:0]    O_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    fe_capture_sequencer #(
        .pDELAY_WIDTH   (DW),
        .pTIMEOUT_WIDTH (TW),
        .pARM_SETTLE    (4)
    ) dut (
        .fe_clk           (fe_clk),
        .reset_i          (reset_i),
        .I_arm            (I_arm),
        .I_abort          (I_abort),
        .I_trigger_mode   (I_trigger_mode),
        .I_trigger_delay  (I_trigger_delay),
        .I_timeout        (I_timeout),
        .I_pm_match       (I_pm_match),
        .I_capturing      (I_capturing),
        .O_arm            (O_arm),
        .O_capture_enable (O_capture_enable),
        .O_trigger        (O_trigger),
        .O_done           (O_done),
        .O_timed_out      (O_timed_out),
        .O_state          (O_state)
    );

    always #5 fe_clk = ~fe_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic a, input logic c, input logic t,
                                       input logic d, input logic o, input logic [2:0] s);
        return {24'd0, a, c, t, d, o, s};
    endfunction

    function automatic logic [31:0] outv();
        return {24'd0, O_arm, O_capture_enable, O_trigger, O_done, O_timed_out, O_state};
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    // Drive a match and count cycles until capture enable rises.
    task automatic measure(input bit extra, output int lat, output int ntrig);
        lat   = -1;
        ntrig = 0;
        I_pm_match = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            I_pm_match = extra && (i % 2 == 1);
            if (O_trigger) ntrig++;
            if (O_capture_enable) begin
                lat = i;
                break;
            end
        end
        I_pm_match = 1'b0;
    endtask

    // Wait for CAPTURE, then count CAPTURE cycles until it is left.
    task automatic capture_len(input int drop_at, input bit arm_poke, output int len);
        len = 0;
        for (int i = 0; i < 20; i++) begin
            if (O_state == 3'd3) break;
            tick();
        end
        if (O_state == 3'd3) begin
            len = 1;
            for (int i = 0; i < 300; i++) begin
                if (len == drop_at) I_capturing = 1'b0;
                if (arm_poke && len == 10) I_arm = 1'b0;
                if (arm_poke && len == 11) I_arm = 1'b1;
                if (len == 3) I_timeout = 24'd5;
                tick();
                if (O_state == 3'd3) len++;
                else break;
            end
        end
    endtask

    task automatic rearm(input bit mode, input logic [DW-1:0] dly, input logic [TW-1:0] to);
        I_arm           = 1'b0;
        I_trigger_mode  = mode;
        I_trigger_delay = dly;
        I_timeout       = to;
        I_capturing     = 1'b1;
        tick();
        I_arm = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        int ntrig;
        int len;

        reset_i         = 1'b1;
        I_arm           = 1'b0;
        I_abort         = 1'b0;
        I_trigger_mode  = 1'b0;
        I_trigger_delay = '0;
        I_timeout       = '0;
        I_pm_match      = 1'b0;
        I_capturing     = 1'b0;
        repeat (2) tick();
        push("reset_outputs", mk(0, 0, 0, 0, 0, 3'd0));
        pop_check(outv());
        #3 reset_i = 1'b0;
        tick();

        // Mode 0, delay 0, timeout 0
        I_capturing = 1'b1;
        I_arm = 1'b1;
        tick();
        push("s1_armed", mk(1, 0, 0, 0, 0, 3'd1));
        pop_check(outv());
        tick();
        I_pm_match = 1'b1;
        tick();
        I_pm_match = 1'b0;
        push("s1_early_match_ignored", mk(1, 0, 0, 0, 0, 3'd1));
        pop_check(outv());
        tick();
        push("s1_latency", 32'd1);
        push("s1_trigger_count", 32'd1);
        measure(1'b0, lat, ntrig);
        pop_check(32'(lat));
        pop_check(32'(ntrig));
        push("s1_capture_entry", mk(1, 1, 1, 0, 0, 3'd3));
        pop_check(outv());
        tick();
        push("s1_trigger_one_cycle", mk(1, 1, 0, 0, 0, 3'd3));
        pop_check(outv());
        repeat (98) tick();
        I_capturing = 1'b0;
        tick();
        push("s1_done", mk(0, 0, 0, 1, 0, 3'd4));
        pop_check(outv());

        // Mode 0, delay 10, re-arm from DONE
        rearm(1'b0, 20'd10, 24'd0);
        push("s2_rearm_from_done", mk(1, 0, 0, 0, 0, 3'd1));
        pop_check(outv());
        repeat (3) tick();
        push("s2_latency", 32'd11);
        push("s2_trigger_count", 32'd1);
        measure(1'b1, lat, ntrig);
        pop_check(32'(lat));
        pop_check(32'(ntrig));
        I_capturing = 1'b0;
        push("s2_first_cycle", mk(1, 1, 0, 0, 0, 3'd3));
        pop_check(outv());
        tick();
        push("s2_capturing_ignored_first", mk(1, 1, 0, 0, 0, 3'd3));
        pop_check(outv());
        tick();
        push("s2_done", mk(0, 0, 0, 1, 0, 3'd4));
        pop_check(outv());

        // Mode 1, timeout 50, capturing falls on the timeout cycle
        rearm(1'b1, 20'd0, 24'd50);
        push("s3b_len", 32'd50);
        capture_len(50, 1'b0, len);
        pop_check(32'(len));
        push("s3b_done_no_timeout", mk(0, 0, 0, 1, 0, 3'd4));
        pop_check(outv());

        // Mode 1, timeout 50, capturing held, arm edge poked mid-capture
        rearm(1'b1, 20'd0, 24'd50);
        push("s3a_len", 32'd50);
        capture_len(0, 1'b1, len);
        pop_check(32'(len));
        push("s3a_done_timeout", mk(0, 0, 0, 1, 1, 3'd4));
        pop_check(outv());

        I_abort = 1'b1;
        tick();
        I_abort = 1'b0;
        push("abort_keeps_timed_out", mk(0, 0, 0, 0, 1, 3'd0));
        pop_check(outv());

        // Abort in DELAY together with an arm edge
        rearm(1'b0, 20'd10, 24'd0);
        I_arm = 1'b0;
        push("s4_rearm_clears_timeout", mk(1, 0, 0, 0, 0, 3'd1));
        pop_check(outv());
        repeat (3) tick();
        I_pm_match = 1'b1;
        tick();
        I_pm_match = 1'b0;
        push("s4_delay_entry", mk(1, 0, 1, 0, 0, 3'd2));
        pop_check(outv());
        repeat (2) tick();
        I_abort = 1'b1;
        I_arm   = 1'b1;
        tick();
        I_abort = 1'b0;
        push("s4_abort_in_delay", mk(0, 0, 0, 0, 0, 3'd0));
        pop_check(outv());
        repeat (2) tick();
        push("s4_no_rearm", mk(0, 0, 0, 0, 0, 3'd0));
        pop_check(outv());
        rearm(1'b1, 20'd0, 24'd0);
        push("s4_later_arm", mk(1, 0, 0, 0, 0, 3'd1));
        pop_check(outv());

        // Async reset mid-CAPTURE
        for (int i = 0; i < 20; i++) begin
            if (O_state == 3'd3) break;
            tick();
        end
        push("s5_in_capture", mk(1, 1, 0, 0, 0, 3'd3));
        repeat (3) tick();
        pop_check(outv());
        #2 reset_i = 1'b1;
        #1;
        push("s5_async_reset", mk(0, 0, 0, 0, 0, 3'd0));
        pop_check(outv());
        I_arm = 1'b0;
        #3 reset_i = 1'b0;
        tick();
        push("s5_after_release", mk(0, 0, 0, 0, 0, 3'd0));
        pop_check(outv());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_capture_sequencer.md
Name: fe_capture_sequencer

Overview:
Sequences the front-end capture datapath. Arms the capture block, then waits for a pattern-match trigger (or triggers immediately). It applies a programmable trigger delay, holds capture enable until the capture block stops or a timeout expires, and reports state and done status to the register block. Sits between the register block / pattern matcher and the capture block's I_arm and I_capture_enable inputs.

Parameters:
pDELAY_WIDTH, 20, width of trigger-delay counter (cycles)
pTIMEOUT_WIDTH, 24, width of capture-timeout counter (cycles)
pARM_SETTLE, 4, cycles spent in ARMED before triggers are accepted (covers capture block arm sync + count clear)

Ports:
fe_clk  in  1  front-end clock; all logic on rising edge
reset_i  in  1  asynchronous active-high reset
I_arm  in  1  arm request level, fe_clk-synchronous; rising edge arms
I_abort  in  1  single-cycle abort pulse
I_trigger_mode  in  1  0 = wait for I_pm_match, 1 = immediate trigger after settle
I_trigger_delay  in  pDELAY_WIDTH  trigger-to-enable delay, cycles
I_timeout  in  pTIMEOUT_WIDTH  max cycles in CAPTURE; 0 = no timeout
I_pm_match  in  1  pattern-match pulse from matcher
I_capturing  in  1  capture-active level from capture block
O_arm  out  1  arm level to capture block
O_capture_enable  out  1  capture enable to capture block
O_trigger  out  1  one-cycle pulse when a trigger is accepted
O_done  out  1  high in DONE
O_timed_out  out  1  sticky; last capture ended by timeout
O_state  out  3  IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4

Behaviour:
- Reset values: state IDLE; all outputs 0. Delay, timeout and settle counters 0. Arm edge register 0.
- All outputs are registered and reflect the current state. O_arm=1 in ARMED/DELAY/CAPTURE. O_capture_enable=1 only in CAPTURE. O_done=1 only in DONE.
- Arm edge: arm_edge = I_arm & !I_arm_q, where I_arm_q is a one-cycle registered copy.
- IDLE: on arm_edge -> ARMED. Settle counter loads pARM_SETTLE-1. I_timeout is latched; O_timed_out clears.
- ARMED: settle counter decrements to 0; triggers are ignored while it is nonzero. Once it is 0, a trigger is accepted when (mode 0 and I_pm_match) or mode 1. On accept: O_trigger=1 for the next cycle and I_trigger_delay is latched. Delay 0 -> CAPTURE. Otherwise -> DELAY, with the delay counter loaded with delay-1.
- DELAY: counter decrements each cycle; at 0 -> CAPTURE. Further I_pm_match pulses are ignored.
- Latency: O_capture_enable rises N+1 cycles after the cycle in which the accepted trigger was sampled, N = latched delay.
- CAPTURE: timeout counter clears on entry and increments each cycle (saturating). The first cycle of CAPTURE does not check I_capturing, to cover the capture-block pipeline. From the second cycle, I_capturing==0 -> DONE. Latched timeout != 0 and counter == timeout-1 -> DONE with O_timed_out=1. If both happen in the same cycle, the I_capturing exit wins and O_timed_out stays 0.
- DONE: holds until arm_edge -> ARMED (same actions as from IDLE). O_arm is low throughout DONE, so the capture block sees a fresh rising edge on re-arm.
- arm_edge in ARMED, DELAY or CAPTURE is ignored (no restart).
- I_abort in any state -> IDLE next cycle, all outputs 0; O_timed_out is preserved. Abort wins over a simultaneous arm_edge, trigger or exit condition, and that arm_edge is discarded.
- I_trigger_delay and I_timeout changes after latching have no effect on the current run.
- Reset asserted mid-run: immediate return to reset values, with no partial O_trigger pulse.

Test Plan:
- Mode 0, delay=0, timeout=0: arm, pm_match in settle cycle 2 then cycle 6 -> first ignored; O_trigger at cycle 7; O_capture_enable rises 1 cycle after the match; I_capturing drops after 100 cycles -> DONE, O_done=1, O_timed_out=0.
- Mode 0, delay=10: match accepted -> state DELAY for 10 cycles; O_capture_enable rises exactly 11 cycles after the match; extra matches during DELAY produce no O_trigger.
- Mode 1, timeout=50, I_capturing held high -> CAPTURE lasts exactly 50 cycles, then DONE with O_timed_out=1; timeout and capturing-fall on the same cycle -> O_timed_out=0.
- Abort in DELAY together with an I_arm rising edge -> IDLE next cycle, all outputs 0, no re-arm; a later arm edge -> ARMED.
- Re-arm from DONE: O_arm goes 0 in DONE then 1 on arm; O_timed_out cleared; arm edge while in CAPTURE ignored.
- Async reset asserted mid-CAPTURE -> outputs 0 immediately without a clock edge; O_state=0 after release.
